// File: rtl/johnson_phase_tracker.sv
// Phase tracker for a 4-bit Johnson counter: decodes codes to phase, locks
// onto a clean sequence, flags illegal codes and sequence breaks, counts revolutions.
module johnson_phase_tracker #(
  parameter int LOCK_CNT   = 3,
  parameter int WRAP_W     = 8,
  parameter int ALLOW_HOLD = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        q_in,
  input  logic              q_valid,
  input  logic              clear_err,
  output logic [2:0]        phase,
  output logic [7:0]        phase_onehot,
  output logic              locked,
  output logic              illegal,
  output logic              seq_err,
  output logic              fault,
  output logic              wrap_pulse,
  output logic [WRAP_W-1:0] wrap_cnt
);

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_LOCKED = 2'd1,
    ST_FAULT  = 2'd2
  } state_t;

  localparam logic [3:0] LOCK_LAST = 4'(LOCK_CNT - 1);

  // Returns {legal, phase}; illegal codes come back as all zeros.
  function automatic logic [3:0] decode(input logic [3:0] code);
    case (code)
      4'h0:    decode = {1'b1, 3'd0};
      4'h1:    decode = {1'b1, 3'd1};
      4'h3:    decode = {1'b1, 3'd2};
      4'h7:    decode = {1'b1, 3'd3};
      4'hF:    decode = {1'b1, 3'd4};
      4'hE:    decode = {1'b1, 3'd5};
      4'hC:    decode = {1'b1, 3'd6};
      4'h8:    decode = {1'b1, 3'd7};
      default: decode = 4'b0000;
    endcase
  endfunction

  state_t            state_q, state_d;
  logic [3:0]        match_q, match_d;
  logic [2:0]        last_phase_q, last_phase_d;
  logic              seeded_q, seeded_d;
  logic [2:0]        phase_q, phase_d;
  logic [7:0]        onehot_q, onehot_d;
  logic              locked_q, locked_d;
  logic              illegal_q, illegal_d;
  logic              seq_err_q, seq_err_d;
  logic              fault_q, fault_d;
  logic              wrap_pulse_q, wrap_pulse_d;
  logic [WRAP_W-1:0] wrap_cnt_q, wrap_cnt_d;

  logic [3:0] dec_s;
  logic       legal_s;
  logic [2:0] samp_phase_s;
  logic       is_succ_s;
  logic       is_rep_s;

  always_comb begin
    dec_s        = decode(q_in);
    legal_s      = dec_s[3];
    samp_phase_s = dec_s[2:0];
    is_succ_s    = (samp_phase_s == (last_phase_q + 3'd1));
    is_rep_s     = (samp_phase_s == last_phase_q);

    state_d      = state_q;
    match_d      = match_q;
    last_phase_d = last_phase_q;
    seeded_d     = seeded_q;
    phase_d      = phase_q;
    wrap_cnt_d   = wrap_cnt_q;
    illegal_d    = 1'b0;
    seq_err_d    = 1'b0;
    wrap_pulse_d = 1'b0;

    case (state_q)
      ST_SEARCH: begin
        if (q_valid && !legal_s) begin
          illegal_d = 1'b1;
          match_d   = 4'd0;
        end else if (q_valid) begin
          last_phase_d = samp_phase_s;
          phase_d      = samp_phase_s;
          seeded_d     = 1'b1;
          // The first legal sample after reset has no predecessor to compare with.
          if (!seeded_q) begin
            match_d = 4'd0;
          end else if (is_succ_s) begin
            match_d = match_q + 4'd1;
            if (match_q == LOCK_LAST) begin
              state_d = ST_LOCKED;
            end else begin
              state_d = ST_SEARCH;
            end
          end else if (is_rep_s && (ALLOW_HOLD != 0)) begin
            match_d = match_q;
          end else begin
            match_d = 4'd0;
          end
        end else begin
          state_d = ST_SEARCH;
        end
      end
      ST_LOCKED: begin
        if (q_valid && !legal_s) begin
          illegal_d = 1'b1;
          match_d   = 4'd0;
          state_d   = ST_FAULT;
        end else if (q_valid && is_succ_s) begin
          last_phase_d = samp_phase_s;
          phase_d      = samp_phase_s;
          if (last_phase_q == 3'd7) begin
            wrap_pulse_d = 1'b1;
            wrap_cnt_d   = wrap_cnt_q + WRAP_W'(1);
          end else begin
            wrap_cnt_d = wrap_cnt_q;
          end
        end else if (q_valid && !(is_rep_s && (ALLOW_HOLD != 0))) begin
          seq_err_d = 1'b1;
          match_d   = 4'd0;
          state_d   = ST_FAULT;
        end else begin
          state_d = ST_LOCKED;
        end
      end
      ST_FAULT: begin
        // A sample arriving together with clear_err is discarded.
        if (clear_err) begin
          state_d = ST_SEARCH;
          match_d = 4'd0;
        end else if (q_valid && !legal_s) begin
          illegal_d = 1'b1;
        end else begin
          state_d = ST_FAULT;
        end
      end
      default: begin
        state_d = ST_SEARCH;
        match_d = 4'd0;
      end
    endcase

    locked_d = (state_d == ST_LOCKED);
    fault_d  = (state_d == ST_FAULT);
    if (locked_d) begin
      onehot_d = 8'd1 << phase_d;
    end else begin
      onehot_d = 8'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_SEARCH;
      match_q      <= 4'd0;
      last_phase_q <= 3'd0;
      seeded_q     <= 1'b0;
      phase_q      <= 3'd0;
      onehot_q     <= 8'd0;
      locked_q     <= 1'b0;
      illegal_q    <= 1'b0;
      seq_err_q    <= 1'b0;
      fault_q      <= 1'b0;
      wrap_pulse_q <= 1'b0;
      wrap_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      match_q      <= match_d;
      last_phase_q <= last_phase_d;
      seeded_q     <= seeded_d;
      phase_q      <= phase_d;
      onehot_q     <= onehot_d;
      locked_q     <= locked_d;
      illegal_q    <= illegal_d;
      seq_err_q    <= seq_err_d;
      fault_q      <= fault_d;
      wrap_pulse_q <= wrap_pulse_d;
      wrap_cnt_q   <= wrap_cnt_d;
    end
  end

  assign phase        = phase_q;
  assign phase_onehot = onehot_q;
  assign locked       = locked_q;
  assign illegal      = illegal_q;
  assign seq_err      = seq_err_q;
  assign fault        = fault_q;
  assign wrap_pulse   = wrap_pulse_q;
  assign wrap_cnt     = wrap_cnt_q;

endmodule
